unita_conv_ctrl: RTL

- Sequencer that drives one conv unit. For each filter it reads the K*K weights from the unit's weight memory into the weight FIFO, then streams one IFM plane into the IFM line FIFO.
- Issues conv_enable for every valid output window and flags valid outputs after the conv pipeline latency.
- Sits between the layer-level top controller / IFM source and the conv unit.

---
 rtl/unita_conv_ctrl_if.sv | 37 +++
 rtl/unita_conv_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/unita_conv_ctrl_if.sv
// ============================================================================
// unita_conv_ctrl_if : control/strobe bundle between the sequencer and its peers
// Rev 1.0
// ============================================================================
`default_nettype none

interface unita_conv_ctrl_if #(
    parameter int ADDRESS_SIZE_WM = 8,
    parameter int FILTER_IDX_W    = 4
);
    logic                       start;
    logic                       ifm_valid;
    logic                       ifm_ready;
    logic                       fifo_enable;
    logic                       wm_enable_read;
    logic [ADDRESS_SIZE_WM-1:0] wm_address;
    logic                       wm_fifo_enable;
    logic                       conv_enable;
    logic                       ofm_valid;
    logic [FILTER_IDX_W-1:0]    filter_idx;
    logic                       busy;
    logic                       done;

    modport master (
        input  start, ifm_valid,
        output ifm_ready, fifo_enable, wm_enable_read, wm_address, wm_fifo_enable,
               conv_enable, ofm_valid, filter_idx, busy, done
    );

    modport slave (
        output start, ifm_valid,
        input  ifm_ready, fifo_enable, wm_enable_read, wm_address, wm_fifo_enable,
               conv_enable, ofm_valid, filter_idx, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/unita_conv_ctrl.sv
// ============================================================================
// unita_conv_ctrl : per-filter weight load + IFM plane stream sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module unita_conv_ctrl #(
    parameter int IFM_SIZE          = 34,
    parameter int KERNAL_SIZE       = 5,
    parameter int NUMBER_OF_FILTERS = 8,
    parameter int CONV_LATENCY      = 3,
    parameter int ADDRESS_SIZE_WM   = $clog2(KERNAL_SIZE*KERNAL_SIZE*NUMBER_OF_FILTERS)
) (
    input wire                clk,
    input wire                reset,
    unita_conv_ctrl_if.master bus
);
    localparam int KK   = KERNAL_SIZE * KERNAL_SIZE;
    localparam int FI_W = $clog2(NUMBER_OF_FILTERS) + 1;
    localparam int RC_W = (IFM_SIZE > 1) ? $clog2(IFM_SIZE) : 1;
    localparam int K_W  = (KK > 1) ? $clog2(KK) : 1;
    localparam int DR_W = $clog2(CONV_LATENCY + 1) + 1;

    localparam logic [RC_W-1:0] C_RC_LAST    = RC_W'(IFM_SIZE - 1);
    localparam logic [RC_W-1:0] C_KM1        = RC_W'(KERNAL_SIZE - 1);
    localparam logic [K_W-1:0]  C_K_LAST     = K_W'(KK - 1);
    localparam logic [FI_W-1:0] C_F_LAST     = FI_W'(NUMBER_OF_FILTERS - 1);
    localparam logic [DR_W-1:0] C_DRAIN_LAST = DR_W'(CONV_LATENCY);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_W     = 3'd1,
        LOAD_FLUSH = 3'd2,
        STREAM     = 3'd3,
        DRAIN      = 3'd4,
        DONE       = 3'd5
    } state_t;

    state_t                     r_state;
    logic [K_W-1:0]             r_k;
    logic [RC_W-1:0]            r_row;
    logic [RC_W-1:0]            r_col;
    logic [DR_W-1:0]            r_drain;
    logic [FI_W-1:0]            r_filter_idx;
    logic [ADDRESS_SIZE_WM-1:0] r_wm_address;
    logic                       r_wm_enable_read;
    logic                       r_wm_fifo_enable;
    logic                       r_ifm_ready;
    logic                       r_conv_enable;
    logic [CONV_LATENCY-1:0]    r_conv_pipe;
    logic                       r_busy;
    logic                       r_done;

    logic                       w_accept;
    logic                       w_window;
    logic [ADDRESS_SIZE_WM-1:0] w_next_base;

    assign w_accept    = bus.ifm_valid & r_ifm_ready;
    assign w_window    = (r_row >= C_KM1) && (r_col >= C_KM1);
    assign w_next_base = ADDRESS_SIZE_WM'((int'(r_filter_idx) + 1) * KK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= IDLE;
            r_k              <= '0;
            r_row            <= '0;
            r_col            <= '0;
            r_drain          <= '0;
            r_filter_idx     <= '0;
            r_wm_address     <= '0;
            r_wm_enable_read <= 1'b0;
            r_wm_fifo_enable <= 1'b0;
            r_ifm_ready      <= 1'b0;
            r_conv_enable    <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            // Weight memory has one cycle of read latency
            r_wm_fifo_enable <= r_wm_enable_read;
            r_conv_enable    <= 1'b0;
            r_done           <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state          <= LOAD_W;
                        r_filter_idx     <= '0;
                        r_k              <= '0;
                        r_wm_address     <= '0;
                        r_wm_enable_read <= 1'b1;
                        r_busy           <= 1'b1;
                    end
                end
                LOAD_W: begin
                    if (r_k == C_K_LAST) begin
                        r_state          <= LOAD_FLUSH;
                        r_wm_enable_read <= 1'b0;
                    end else begin
                        r_k          <= r_k + K_W'(1);
                        r_wm_address <= r_wm_address + ADDRESS_SIZE_WM'(1);
                    end
                end
                LOAD_FLUSH: begin
                    r_state     <= STREAM;
                    r_row       <= '0;
                    r_col       <= '0;
                    r_ifm_ready <= 1'b1;
                end
                STREAM: begin
                    if (w_accept) begin
                        r_conv_enable <= w_window;
                        if (r_col == C_RC_LAST) begin
                            r_col <= '0;
                            if (r_row == C_RC_LAST) begin
                                r_state     <= DRAIN;
                                r_ifm_ready <= 1'b0;
                                r_row       <= '0;
                                r_drain     <= '0;
                            end else begin
                                r_row <= r_row + RC_W'(1);
                            end
                        end else begin
                            r_col <= r_col + RC_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Hold until the last window has left the conv pipeline
                    if (r_drain == C_DRAIN_LAST) begin
                        if (r_filter_idx < C_F_LAST) begin
                            r_state          <= LOAD_W;
                            r_filter_idx     <= r_filter_idx + FI_W'(1);
                            r_k              <= '0;
                            r_wm_address     <= w_next_base;
                            r_wm_enable_read <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_drain <= r_drain + DR_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_conv_pipe <= '0;
        end else begin
            r_conv_pipe[0] <= r_conv_enable;
            for (int i = 1; i < CONV_LATENCY; i++) begin
                r_conv_pipe[i] <= r_conv_pipe[i-1];
            end
        end
    end

    assign bus.ifm_ready      = r_ifm_ready;
    assign bus.fifo_enable    = w_accept;
    assign bus.wm_enable_read = r_wm_enable_read;
    assign bus.wm_address     = r_wm_address;
    assign bus.wm_fifo_enable = r_wm_fifo_enable;
    assign bus.conv_enable    = r_conv_enable;
    assign bus.ofm_valid      = r_conv_pipe[CONV_LATENCY-1];
    assign bus.filter_idx     = r_filter_idx;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;

endmodule

`default_nettype wire
